// File: rtl/clock_set_fsm_param_if.sv
// ---------------------------------------------------------------------------
// clock_set_fsm_param_if
// Button inputs and display/status outputs of the settable BCD clock.
//   i_setbutton, i_button1, i_button2 : user buttons (level, edge-detected
//                                      inside the clock)
//   o_hour1/o_hour2, o_min1/o_min2,
//   o_sec1/o_sec2                      : BCD time digits (tens/units)
//   o_pm                               : PM flag (12-hour mode only)
//   o_set_state                        : 0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
//   o_tick                             : one-cycle pulse per run-mode second
//   o_blink                            : blink enable for the edited field
// master = button/display side, slave = clock core.
// ---------------------------------------------------------------------------
interface clock_set_fsm_param_if;
    logic       i_setbutton;
    logic       i_button1;
    logic       i_button2;
    logic [1:0] o_hour1;
    logic [3:0] o_hour2;
    logic [2:0] o_min1;
    logic [3:0] o_min2;
    logic [2:0] o_sec1;
    logic [3:0] o_sec2;
    logic       o_pm;
    logic [1:0] o_set_state;
    logic       o_tick;
    logic       o_blink;

    modport master (
        output i_setbutton, i_button1, i_button2,
        input  o_hour1, o_hour2, o_min1, o_min2, o_sec1, o_sec2,
        input  o_pm, o_set_state, o_tick, o_blink
    );

    modport slave (
        input  i_setbutton, i_button1, i_button2,
        output o_hour1, o_hour2, o_min1, o_min2, o_sec1, o_sec2,
        output o_pm, o_set_state, o_tick, o_blink
    );
endinterface

// File: rtl/clock_set_fsm_param.sv
// ---------------------------------------------------------------------------
// clock_set_fsm_param
// BCD HH:MM:SS clock driven by a prescaled system clock, with a
// RUN -> SET_HOUR -> SET_MIN -> SET_SEC edit cycle, 12/24-hour mode,
// button edge detection and an inactivity timeout back to RUN.
//   i_clk   : system clock, rising edge
//   i_reset : synchronous, active-high
//   bus     : clock_set_fsm_param_if.slave (buttons in, display/status out)
// ---------------------------------------------------------------------------
module clock_set_fsm_param #(
    parameter int TICKS_PER_SEC = 100,
    parameter int MODE_24H      = 1,
    parameter int TIMEOUT_SEC   = 30
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    clock_set_fsm_param_if.slave         bus
);
    localparam int PW      = $clog2(TICKS_PER_SEC);
    localparam int TW      = (TIMEOUT_SEC > 0) ? $clog2(TIMEOUT_SEC + 1) : 1;
    localparam int TMO_LIM = (TIMEOUT_SEC > 0) ? TIMEOUT_SEC - 1 : 0;
    localparam logic [PW-1:0] P_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] P_HALF = PW'(TICKS_PER_SEC / 2);
    // 12-hour mode powers up at 12:00:00 AM
    localparam logic [1:0] H1_RST = (MODE_24H != 0) ? 2'd0 : 2'd1;
    localparam logic [3:0] H2_RST = (MODE_24H != 0) ? 4'd0 : 4'd2;

    typedef enum logic [1:0] {S_RUN = 2'd0, S_HOUR = 2'd1, S_MIN = 2'd2, S_SEC = 2'd3} state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [TW-1:0] r_tmo,   w_tmo_nxt;
    logic          r_sb_q, r_b1_q, r_b2_q;
    logic [1:0]    r_h1, w_h1_nxt;
    logic [3:0]    r_h2, w_h2_nxt;
    logic [2:0]    r_m1, w_m1_nxt;
    logic [3:0]    r_m2, w_m2_nxt;
    logic [2:0]    r_s1, w_s1_nxt;
    logic [3:0]    r_s2, w_s2_nxt;
    logic          r_pm, w_pm_nxt;

    logic w_e_sb, w_e_b1, w_e_b2, w_wrap;
    assign w_e_sb = bus.i_setbutton & ~r_sb_q;
    assign w_e_b1 = bus.i_button1   & ~r_b1_q;
    assign w_e_b2 = bus.i_button2   & ~r_b2_q;
    assign w_wrap = (r_presc == P_MAX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_RUN;
            r_presc <= '0;
            r_tmo   <= '0;
            r_sb_q  <= 1'b0;
            r_b1_q  <= 1'b0;
            r_b2_q  <= 1'b0;
            r_h1    <= H1_RST;
            r_h2    <= H2_RST;
            r_m1    <= '0;
            r_m2    <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_pm    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_tmo   <= w_tmo_nxt;
            r_sb_q  <= bus.i_setbutton;
            r_b1_q  <= bus.i_button1;
            r_b2_q  <= bus.i_button2;
            r_h1    <= w_h1_nxt;
            r_h2    <= w_h2_nxt;
            r_m1    <= w_m1_nxt;
            r_m2    <= w_m2_nxt;
            r_s1    <= w_s1_nxt;
            r_s2    <= w_s2_nxt;
            r_pm    <= w_pm_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = w_wrap ? '0 : r_presc + PW'(1);
        w_tmo_nxt   = r_tmo;
        w_h1_nxt    = r_h1;
        w_h2_nxt    = r_h2;
        w_m1_nxt    = r_m1;
        w_m2_nxt    = r_m2;
        w_s1_nxt    = r_s1;
        w_s2_nxt    = r_s2;
        w_pm_nxt    = r_pm;

        if (r_state == S_RUN) begin
            if (w_e_sb) begin
                w_state_nxt = S_HOUR;
                w_tmo_nxt   = '0;
            end
            // Second advance with full ripple carry through to the hours
            if (w_wrap) begin
                if (r_s2 != 4'd9) w_s2_nxt = r_s2 + 4'd1;
                else begin
                    w_s2_nxt = 4'd0;
                    if (r_s1 != 3'd5) w_s1_nxt = r_s1 + 3'd1;
                    else begin
                        w_s1_nxt = 3'd0;
                        if (r_m2 != 4'd9) w_m2_nxt = r_m2 + 4'd1;
                        else begin
                            w_m2_nxt = 4'd0;
                            if (r_m1 != 3'd5) w_m1_nxt = r_m1 + 3'd1;
                            else begin
                                w_m1_nxt = 3'd0;
                                if (MODE_24H != 0) begin
                                    if (r_h1 == 2'd2 && r_h2 == 4'd3) begin
                                        w_h1_nxt = 2'd0; w_h2_nxt = 4'd0;
                                    end else if (r_h2 == 4'd9) begin
                                        w_h1_nxt = r_h1 + 2'd1; w_h2_nxt = 4'd0;
                                    end else w_h2_nxt = r_h2 + 4'd1;
                                end else begin
                                    // 11->12 flips AM/PM, 12->01 does not
                                    if (r_h1 == 2'd1 && r_h2 == 4'd1) begin
                                        w_h2_nxt = 4'd2; w_pm_nxt = ~r_pm;
                                    end else if (r_h1 == 2'd1 && r_h2 == 4'd2) begin
                                        w_h1_nxt = 2'd0; w_h2_nxt = 4'd1;
                                    end else if (r_h2 == 4'd9) begin
                                        w_h1_nxt = 2'd1; w_h2_nxt = 4'd0;
                                    end else w_h2_nxt = r_h2 + 4'd1;
                                end
                            end
                        end
                    end
                end
            end
        end else if (w_e_sb) begin
            // setbutton wins; same-cycle digit edges are dropped
            w_state_nxt = (r_state == S_HOUR) ? S_MIN : (r_state == S_MIN) ? S_SEC : S_RUN;
            w_tmo_nxt   = '0;
        end else if (w_e_b1 || w_e_b2) begin
            w_tmo_nxt = '0;
            case (r_state)
                S_HOUR: begin
                    if (MODE_24H != 0) begin
                        if (w_e_b1) begin
                            w_h1_nxt = (r_h1 == 2'd2) ? 2'd0 : r_h1 + 2'd1;
                            if (r_h1 == 2'd1 && r_h2 > 4'd3) w_h2_nxt = 4'd0;
                        end else if (r_h1 == 2'd2)
                            w_h2_nxt = (r_h2 >= 4'd3) ? 4'd0 : r_h2 + 4'd1;
                        else
                            w_h2_nxt = (r_h2 >= 4'd9) ? 4'd0 : r_h2 + 4'd1;
                    end else begin
                        if (w_e_b1 && w_e_b2) w_pm_nxt = ~r_pm;
                        else if (w_e_b1) begin
                            if (r_h1 == 2'd0) begin
                                w_h1_nxt = 2'd1;
                                if (r_h2 > 4'd2) w_h2_nxt = 4'd0;
                            end else begin
                                w_h1_nxt = 2'd0;
                                if (r_h2 == 4'd0) w_h2_nxt = 4'd1;
                            end
                        end else if (r_h1 == 2'd0)
                            w_h2_nxt = (r_h2 >= 4'd9) ? 4'd1 : r_h2 + 4'd1;
                        else
                            w_h2_nxt = (r_h2 >= 4'd2) ? 4'd0 : r_h2 + 4'd1;
                    end
                end
                S_MIN: begin
                    if (w_e_b1) w_m1_nxt = (r_m1 >= 3'd5) ? 3'd0 : r_m1 + 3'd1;
                    else        w_m2_nxt = (r_m2 >= 4'd9) ? 4'd0 : r_m2 + 4'd1;
                end
                default: begin
                    if (w_e_b1) w_s1_nxt = (r_s1 >= 3'd5) ? 3'd0 : r_s1 + 3'd1;
                    else        w_s2_nxt = (r_s2 >= 4'd9) ? 4'd0 : r_s2 + 4'd1;
                end
            endcase
        end else if (w_wrap && TIMEOUT_SEC != 0) begin
            if (r_tmo == TW'(TMO_LIM)) begin
                w_state_nxt = S_RUN;
                w_tmo_nxt   = '0;
            end else w_tmo_nxt = r_tmo + TW'(1);
        end

        // Re-entering RUN restarts the second so the first tick is a full second away
        if (r_state != S_RUN && w_state_nxt == S_RUN) w_presc_nxt = '0;
    end

    assign bus.o_hour1     = r_h1;
    assign bus.o_hour2     = r_h2;
    assign bus.o_min1      = r_m1;
    assign bus.o_min2      = r_m2;
    assign bus.o_sec1      = r_s1;
    assign bus.o_sec2      = r_s2;
    assign bus.o_pm        = (MODE_24H != 0) ? 1'b0 : r_pm;
    assign bus.o_set_state = r_state;
    assign bus.o_tick      = (r_state == S_RUN) && w_wrap;
    assign bus.o_blink     = (r_state == S_RUN) ? 1'b1 : (r_presc < P_HALF);
endmodule

// File: tb/tb_clock_set_fsm_param.sv
module tb_clock_set_fsm_param;
    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] sb  = 2'b00;
    logic [1:0] b1  = 2'b00;
    logic [1:0] b2  = 2'b00;
    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clock_set_fsm_param_if if24();
    clock_set_fsm_param_if if12();
    assign if24.i_setbutton = sb[0];
    assign if24.i_button1   = b1[0];
    assign if24.i_button2   = b2[0];
    assign if12.i_setbutton = sb[1];
    assign if12.i_button1   = b1[1];
    assign if12.i_button2   = b2[1];

    clock_set_fsm_param #(.TICKS_PER_SEC(4), .MODE_24H(1), .TIMEOUT_SEC(3)) dut24 (
        .i_clk(clk), .i_reset(rst[0]), .bus(if24));
    clock_set_fsm_param #(.TICKS_PER_SEC(4), .MODE_24H(0), .TIMEOUT_SEC(0)) dut12 (
        .i_clk(clk), .i_reset(rst[1]), .bus(if12));

    typedef struct {
        bit          s, x, y;
        logic [1:0]  st;
        logic [23:0] t;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit s, x, y, input logic [1:0] st, input logic [23:0] t);
        vec_t v;
        v.s = s; v.x = x; v.y = y; v.st = st; v.t = t;
        tbl.push_back(v);
    endfunction

    // time as packed BCD HHMMSS
    function automatic logic [23:0] tm(input int d);
        if (d == 0) return {2'b0, if24.o_hour1, if24.o_hour2, 1'b0, if24.o_min1, if24.o_min2,
                            1'b0, if24.o_sec1, if24.o_sec2};
        return {2'b0, if12.o_hour1, if12.o_hour2, 1'b0, if12.o_min1, if12.o_min2,
                1'b0, if12.o_sec1, if12.o_sec2};
    endfunction
    function automatic logic [1:0] st(input int d);
        return (d == 0) ? if24.o_set_state : if12.o_set_state;
    endfunction
    function automatic logic tk(input int d);
        return (d == 0) ? if24.o_tick : if12.o_tick;
    endfunction
    function automatic logic bl(input int d);
        return (d == 0) ? if24.o_blink : if12.o_blink;
    endfunction
    function automatic logic pmf(input int d);
        return (d == 0) ? if24.o_pm : if12.o_pm;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // one cycle of buttons, then one idle cycle
    task automatic press(input int d, input bit s, input bit x, input bit y);
        sb[d] = s; b1[d] = x; b2[d] = y;
        step();
        sb[d] = 1'b0; b1[d] = 1'b0; b2[d] = 1'b0;
        step();
    endtask

    task automatic presses(input int d, input int n, input bit x, input bit y);
        for (int i = 0; i < n; i++) press(d, 1'b0, x, y);
    endtask

    task automatic do_reset(input int d, input logic [23:0] t0);
        rst[d] = 1'b1;
        repeat (3) step();
        chk("rst_state", st(d), 2'd0);
        chk("rst_time", tm(d), t0);
        chk("rst_tick", tk(d), 1'b0);
        chk("rst_blink", bl(d), 1'b1);
        chk("rst_pm", pmf(d), 1'b0);
        rst[d] = 1'b0;
    endtask

    initial begin
        int last, first, ntick, badgap;

        // 24-hour edit vectors: each row is one press, expectations after it
        add(1,0,0, 2'd1, 24'h000000);
        add(0,1,0, 2'd1, 24'h100000);
        add(0,1,0, 2'd1, 24'h200000);
        add(0,0,1, 2'd1, 24'h210000);
        add(0,0,1, 2'd1, 24'h220000);
        add(0,0,1, 2'd1, 24'h230000);
        add(0,0,1, 2'd1, 24'h200000);
        add(0,0,1, 2'd1, 24'h210000);
        add(0,0,1, 2'd1, 24'h220000);
        add(0,0,1, 2'd1, 24'h230000);
        add(1,0,0, 2'd2, 24'h230000);
        for (int i = 1; i <= 5; i++) add(0,1,0, 2'd2, 24'h230000 | 24'(i << 12));
        for (int i = 1; i <= 9; i++) add(0,0,1, 2'd2, 24'h235000 | 24'(i << 8));
        add(0,0,1, 2'd2, 24'h235000);
        for (int i = 1; i <= 9; i++) add(0,0,1, 2'd2, 24'h235000 | 24'(i << 8));
        add(1,0,0, 2'd3, 24'h235900);
        add(0,1,1, 2'd3, 24'h235910);
        for (int i = 2; i <= 5; i++) add(0,1,0, 2'd3, 24'h235900 | 24'(i << 4));
        add(0,1,0, 2'd3, 24'h235900);
        for (int i = 1; i <= 5; i++) add(0,1,0, 2'd3, 24'h235900 | 24'(i << 4));
        for (int i = 1; i <= 9; i++) add(0,0,1, 2'd3, 24'h235950 | 24'(i));
        add(1,0,0, 2'd0, 24'h235959);

        // free run: 240 cycles -> 00:01:00, 60 ticks 4 cycles apart
        do_reset(0, 24'h000000);
        last = -1; first = -1; ntick = 0; badgap = 0;
        for (int c = 1; c <= 240; c++) begin
            step();
            if (tk(0)) begin
                ntick++;
                if (first < 0) first = c;
                if (last >= 0 && c - last != 4) badgap++;
                last = c;
            end
        end
        chk("run_ticks", 32'(ntick), 32'd60);
        chk("run_first_tick", 32'(first), 32'd3);
        chk("run_tick_gaps", 32'(badgap), 32'd0);
        chk("run_time", tm(0), 24'h000100);

        // table-driven 24-hour edit
        do_reset(0, 24'h000000);
        foreach (tbl[k]) begin
            press(0, tbl[k].s, tbl[k].x, tbl[k].y);
            chk($sformatf("vec%0d_state", k), st(0), tbl[k].st);
            chk($sformatf("vec%0d_time", k), tm(0), tbl[k].t);
        end
        repeat (2) step();
        chk("roll24_tick", tk(0), 1'b1);
        step();
        chk("roll24_time", tm(0), 24'h000000);

        // 24-hour tens clamp
        do_reset(0, 24'h000000);
        press(0, 1'b1, 1'b0, 1'b0);
        press(0, 1'b0, 1'b1, 1'b0);
        presses(0, 9, 1'b0, 1'b1);
        chk("clamp_19", tm(0), 24'h190000);
        press(0, 1'b0, 1'b1, 1'b0);
        chk("clamp_19_to_20", tm(0), 24'h200000);
        press(0, 1'b0, 1'b1, 1'b0);
        chk("clamp_tens_wrap", tm(0), 24'h000000);
        presses(0, 9, 1'b0, 1'b1);
        presses(0, 2, 1'b1, 1'b0);
        chk("clamp_09_to_20", tm(0), 24'h200000);

        // timeout: enter SET_MIN on a prescaler wrap, then idle
        do_reset(0, 24'h000000);
        step();
        sb[0] = 1'b1; step(); sb[0] = 1'b0;
        step();
        sb[0] = 1'b1; step(); sb[0] = 1'b0;
        chk("tmo_in_min", st(0), 2'd2);
        repeat (2) step();
        chk("tmo_blink_low", bl(0), 1'b0);
        chk("tmo_tick_set", tk(0), 1'b0);
        repeat (9) step();
        chk("tmo_before", st(0), 2'd2);
        step();
        chk("tmo_after12", st(0), 2'd0);
        // same entry, but a button2 edge 10 cycles in restarts the count
        step();
        sb[0] = 1'b1; step(); sb[0] = 1'b0;
        step();
        sb[0] = 1'b1; step(); sb[0] = 1'b0;
        repeat (9) step();
        b2[0] = 1'b1; step(); b2[0] = 1'b0;
        chk("tmo_b2_edit", tm(0), 24'h000100);
        repeat (9) step();
        chk("tmo_restart_hold", st(0), 2'd2);
        step();
        chk("tmo_restart_exit", st(0), 2'd0);
        repeat (3) step();
        chk("tmo_first_tick", tk(0), 1'b1);
        step();
        chk("tmo_run_sec", tm(0), 24'h000101);

        // buttons ignored in RUN, then reset mid-edit
        do_reset(0, 24'h000000);
        press(0, 1'b0, 1'b1, 1'b0);
        chk("run_ignore_b1", tm(0), 24'h000000);
        press(0, 1'b1, 1'b0, 1'b0);
        presses(0, 7, 1'b0, 1'b1);
        press(0, 1'b1, 1'b0, 1'b0);
        presses(0, 3, 1'b1, 1'b0);
        press(0, 1'b1, 1'b0, 1'b0);
        presses(0, 5, 1'b0, 1'b1);
        chk("mid_state", st(0), 2'd3);
        chk("mid_time", tm(0), 24'h073005);
        rst[0] = 1'b1; step();
        chk("mid_rst_time", tm(0), 24'h000000);
        chk("mid_rst_state", st(0), 2'd0);
        rst[0] = 1'b0;

        // 12-hour mode
        do_reset(1, 24'h120000);
        press(1, 1'b1, 1'b0, 1'b0);
        press(1, 1'b0, 1'b0, 1'b1);
        chk("h12_b2_wrap", tm(1), 24'h100000);
        press(1, 1'b0, 1'b0, 1'b1);
        press(1, 1'b1, 1'b0, 1'b0);
        presses(1, 5, 1'b1, 1'b0);
        presses(1, 9, 1'b0, 1'b1);
        press(1, 1'b1, 1'b0, 1'b0);
        presses(1, 5, 1'b1, 1'b0);
        presses(1, 9, 1'b0, 1'b1);
        press(1, 1'b1, 1'b0, 1'b0);
        chk("h12_set_115959", tm(1), 24'h115959);
        chk("h12_set_state", st(1), 2'd0);
        repeat (3) step();
        chk("h12_noon_time", tm(1), 24'h120000);
        chk("h12_noon_pm", pmf(1), 1'b1);

        // edge detection and latency in SET_MIN
        press(1, 1'b1, 1'b0, 1'b0);
        press(1, 1'b1, 1'b0, 1'b0);
        b2[1] = 1'b1; step();
        chk("edge_latency", tm(1), 24'h120100);
        repeat (9) step();
        chk("edge_held_once", tm(1), 24'h120100);
        b2[1] = 1'b0; step();
        sb[1] = 1'b1; b1[1] = 1'b1; step();
        chk("sb_prio_state", st(1), 2'd3);
        chk("sb_prio_time", tm(1), 24'h120100);
        sb[1] = 1'b0; b1[1] = 1'b0; step();

        // 12:59:59 -> 01:00:00, pm unchanged
        press(1, 1'b1, 1'b0, 1'b0);
        press(1, 1'b1, 1'b0, 1'b0);
        press(1, 1'b1, 1'b0, 1'b0);
        presses(1, 5, 1'b1, 1'b0);
        presses(1, 8, 1'b0, 1'b1);
        press(1, 1'b1, 1'b0, 1'b0);
        presses(1, 5, 1'b1, 1'b0);
        presses(1, 9, 1'b0, 1'b1);
        press(1, 1'b1, 1'b0, 1'b0);
        chk("h12_set_125959", tm(1), 24'h125959);
        repeat (3) step();
        chk("h12_one_time", tm(1), 24'h010000);
        chk("h12_one_pm", pmf(1), 1'b1);

        // 12-hour hour edits
        press(1, 1'b1, 1'b0, 1'b0);
        press(1, 1'b0, 1'b1, 1'b0);
        chk("h12_01_to_11", tm(1), 24'h110000);
        presses(1, 2, 1'b0, 1'b1);
        chk("h12_to_10", tm(1), 24'h100000);
        press(1, 1'b0, 1'b1, 1'b0);
        chk("h12_10_to_01", tm(1), 24'h010000);
        press(1, 1'b0, 1'b1, 1'b1);
        chk("h12_pair_time", tm(1), 24'h010000);
        chk("h12_pair_pm", pmf(1), 1'b0);
        presses(1, 8, 1'b0, 1'b1);
        chk("h12_to_09", tm(1), 24'h090000);
        press(1, 1'b0, 1'b1, 1'b0);
        chk("h12_09_to_10", tm(1), 24'h100000);
        press(1, 1'b0, 1'b1, 1'b0);
        presses(1, 8, 1'b0, 1'b1);
        press(1, 1'b0, 1'b0, 1'b1);
        chk("h12_units_wrap", tm(1), 24'h010000);
        repeat (20) step();
        chk("h12_no_timeout", st(1), 2'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
